// File: rtl/lsu_tlul_host.sv
// lsu_tlul_host: bridges the LSU req/gnt/rvalid data port onto a TL-UL host port.
//   clk_i, rst_ni          clock / async active-low reset
//   data_req_i..wdata_i    LSU request (held stable until data_gnt_o)
//   data_gnt_o             A-channel handshake completed this cycle
//   data_rvalid_o/rdata_o/err_o  registered response, one pulse per transaction
//   tl_o / tl_i            TL-UL A channel + d_ready / D channel + a_ready
// Up to MaxOutstanding transactions are tracked; responses are expected in order.

package tlul_pkg;
  localparam int unsigned TlSrcW = 8;
  localparam logic [15:0] TlUserDefault = 16'h0000;

  typedef enum logic [2:0] {
    PutFullData    = 3'h0,
    PutPartialData = 3'h1,
    Get            = 3'h4
  } tl_a_op_e;

  typedef enum logic [2:0] {
    AccessAck     = 3'h0,
    AccessAckData = 3'h1
  } tl_d_op_e;

  typedef struct packed {
    logic              a_valid;
    tl_a_op_e          a_opcode;
    logic [2:0]        a_param;
    logic [1:0]        a_size;
    logic [TlSrcW-1:0] a_source;
    logic [31:0]       a_address;
    logic [3:0]        a_mask;
    logic [31:0]       a_data;
    logic [15:0]       a_user;
    logic              d_ready;
  } tl_h2d_t;

  typedef struct packed {
    logic              d_valid;
    tl_d_op_e          d_opcode;
    logic [2:0]        d_param;
    logic [1:0]        d_size;
    logic [TlSrcW-1:0] d_source;
    logic              d_sink;
    logic [31:0]       d_data;
    logic [15:0]       d_user;
    logic              d_error;
    logic              a_ready;
  } tl_d2h_t;
endpackage

module lsu_tlul_host
  import tlul_pkg::*;
#(
  parameter int unsigned MaxOutstanding = 2,
  parameter int unsigned SrcW           = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        data_req_i,
  output logic        data_gnt_o,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_wdata_i,
  output logic        data_rvalid_o,
  output logic [31:0] data_rdata_o,
  output logic        data_err_o,
  output tl_h2d_t     tl_o,
  input  tl_d2h_t     tl_i
);

  localparam int unsigned CntW = $clog2(MaxOutstanding + 1);

  logic [CntW-1:0] r_cnt;
  logic [SrcW-1:0] r_src_ptr;
  logic [SrcW-1:0] r_exp_src;
  logic            r_rvalid;
  logic [31:0]     r_rdata;
  logic            r_err;

  logic            w_a_valid;
  logic            w_gnt;
  logic            w_rsp;
  logic [CntW-1:0] w_cnt_d;
  logic            w_unused;

  assign w_a_valid = data_req_i & (r_cnt < CntW'(MaxOutstanding));
  assign w_gnt     = w_a_valid & tl_i.a_ready;
  // A response with nothing outstanding is spurious (e.g. issued before a reset) and dropped.
  assign w_rsp     = tl_i.d_valid & (r_cnt != '0);

  always_comb begin
    w_cnt_d = r_cnt;
    if (w_gnt && !w_rsp) begin
      w_cnt_d = r_cnt + 1'b1;
    end else if (!w_gnt && w_rsp) begin
      w_cnt_d = r_cnt - 1'b1;
    end
  end

  always_comb begin
    tl_o.a_valid   = w_a_valid;
    tl_o.a_param   = 3'b000;
    tl_o.a_size    = 2'd2;
    tl_o.a_source  = TlSrcW'(r_src_ptr);
    tl_o.a_address = {data_addr_i[31:2], 2'b00};
    tl_o.a_data    = data_wdata_i;
    tl_o.a_user    = TlUserDefault;
    tl_o.d_ready   = 1'b1;
    if (!data_we_i) begin
      tl_o.a_opcode = Get;
      tl_o.a_mask   = 4'hF;
    end else begin
      tl_o.a_opcode = (data_be_i == 4'hF) ? PutFullData : PutPartialData;
      tl_o.a_mask   = data_be_i;
    end
  end

  assign data_gnt_o    = w_gnt;
  assign data_rvalid_o = r_rvalid;
  assign data_rdata_o  = r_rdata;
  assign data_err_o    = r_err;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cnt     <= '0;
      r_src_ptr <= '0;
      r_exp_src <= '0;
      r_rvalid  <= 1'b0;
      r_rdata   <= '0;
      r_err     <= 1'b0;
    end else begin
      r_cnt    <= w_cnt_d;
      r_rvalid <= w_rsp;
      if (w_gnt) begin
        r_src_ptr <= (r_src_ptr == SrcW'(MaxOutstanding - 1)) ? '0 : r_src_ptr + 1'b1;
      end
      // rdata/err hold between responses.
      if (w_rsp) begin
        r_rdata   <= (tl_i.d_opcode == AccessAckData) ? tl_i.d_data : '0;
        r_err     <= tl_i.d_error | (tl_i.d_source != TlSrcW'(r_exp_src));
        r_exp_src <= (r_exp_src == SrcW'(MaxOutstanding - 1)) ? '0 : r_exp_src + 1'b1;
      end
    end
  end

  // D-channel fields this host has no use for.
  assign w_unused = ^{tl_i.d_param, tl_i.d_size, tl_i.d_sink, tl_i.d_user, data_addr_i[1:0]};

endmodule
